// File: rtl/uart_tx_core.sv
// UART frame transmitter: start, 8 data bits, optional parity, stop bits.
// Bit time is AcqPeriod x AcqNumPerBit clocks, captured per frame on accept.
module uart_tx_core #(
  parameter int   STOP_BITS  = 1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p_DataValid_i,
  input  logic [7:0] Data_i,
  output logic       p_DataReady_o,
  input  logic [11:0] AcqPeriod_i,
  input  logic [3:0] AcqNumPerBit_i,
  input  logic       p_ParityEnable_i,
  input  logic       ParityMethod_i,
  input  logic       p_BigEnd_i,
  output logic       Tx_o,
  output logic       p_Busy_o,
  output logic       p_FrameDone_o
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  state_t      state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic [11:0] per_q, per_d, pre_q, pre_d;
  logic [3:0]  num_q, num_d, tick_q, tick_d;
  logic        par_en_q, par_en_d, par_odd_q, par_odd_d, big_q, big_d;
  logic [2:0]  bit_idx_q, bit_idx_d, bit_sel;
  logic        stop_cnt_q, stop_cnt_d;
  logic        tx_q, tx_d;
  logic        done;
  logic        bit_end;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    per_d      = per_q;
    num_d      = num_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    big_d      = big_q;
    pre_d      = pre_q;
    tick_d     = tick_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    done       = 1'b0;
    bit_end    = (state_q != S_IDLE) && (pre_q == per_q - 12'd1) &&
                 (tick_q == num_q - 4'd1);

    // prescaler wraps at P-1, tick counter at N-1
    if (state_q != S_IDLE) begin
      if (pre_q == per_q - 12'd1) begin
        pre_d  = 12'd0;
        tick_d = (tick_q == num_q - 4'd1) ? 4'd0 : tick_q + 4'd1;
      end else begin
        pre_d = pre_q + 12'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (p_DataValid_i) begin
          data_d     = Data_i;
          per_d      = (AcqPeriod_i == 12'd0) ? 12'd1 : AcqPeriod_i;
          num_d      = (AcqNumPerBit_i == 4'd0) ? 4'd1 : AcqNumPerBit_i;
          par_en_d   = p_ParityEnable_i;
          par_odd_d  = ParityMethod_i;
          big_d      = p_BigEnd_i;
          pre_d      = 12'd0;
          tick_d     = 4'd0;
          bit_idx_d  = 3'd0;
          stop_cnt_d = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = S_IDLE;
            done    = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // line level follows the state being entered so Tx_o stays registered
    bit_sel = big_q ? (3'd7 - bit_idx_d) : bit_idx_d;
    case (state_d)
      S_START:  tx_d = ~IDLE_LEVEL;
      S_DATA:   tx_d = data_q[bit_sel];
      S_PARITY: tx_d = par_odd_q ? ~(^data_q) : (^data_q);
      default:  tx_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      data_q     <= 8'd0;
      per_q      <= 12'd0;
      num_q      <= 4'd0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      big_q      <= 1'b0;
      pre_q      <= 12'd0;
      tick_q     <= 4'd0;
      bit_idx_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      tx_q       <= IDLE_LEVEL;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      per_q      <= per_d;
      num_q      <= num_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      big_q      <= big_d;
      pre_q      <= pre_d;
      tick_q     <= tick_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
    end
  end

  assign p_DataReady_o = (state_q == S_IDLE);
  assign p_Busy_o      = (state_q != S_IDLE);
  assign p_FrameDone_o = done;
  assign Tx_o          = tx_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench: per-clock expected {tx, busy, done, ready} pushed on accept.
module tb_uart_tx_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid1, valid2;
  logic [7:0]  data;
  logic [11:0] acq_p;
  logic [3:0]  acq_n;
  logic        pen, podd, big;
  logic        tx1, ready1, busy1, done1;
  logic        tx2, ready2, busy2, done2;
  logic        mon_on;
  logic [3:0]  e1, e2;
  logic [3:0]  q1[$];
  logic [3:0]  q2[$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  uart_tx_core #(.STOP_BITS(1), .IDLE_LEVEL(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .p_DataValid_i(valid1), .Data_i(data),
    .p_DataReady_o(ready1), .AcqPeriod_i(acq_p), .AcqNumPerBit_i(acq_n),
    .p_ParityEnable_i(pen), .ParityMethod_i(podd), .p_BigEnd_i(big),
    .Tx_o(tx1), .p_Busy_o(busy1), .p_FrameDone_o(done1)
  );

  uart_tx_core #(.STOP_BITS(2), .IDLE_LEVEL(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .p_DataValid_i(valid2), .Data_i(data),
    .p_DataReady_o(ready2), .AcqPeriod_i(acq_p), .AcqNumPerBit_i(acq_n),
    .p_ParityEnable_i(pen), .ParityMethod_i(podd), .p_BigEnd_i(big),
    .Tx_o(tx2), .p_Busy_o(busy2), .p_FrameDone_o(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // expected per-clock trace of one frame, using the config seen at accept
  task automatic push_frame(input int which, input logic [7:0] d);
    int p, n, t, nb;
    logic bits[13];
    logic [3:0] e;
    p = (acq_p == 12'd0) ? 1 : int'(acq_p);
    n = (acq_n == 4'd0) ? 1 : int'(acq_n);
    t = p * n;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = big ? d[7-i] : d[i];
    nb = 9;
    if (pen) begin
      bits[9] = podd ? ~(^d) : (^d);
      nb = 10;
    end
    for (int s = 0; s < ((which == 1) ? 1 : 2); s++) begin
      bits[nb] = 1'b1;
      nb++;
    end
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < t; c++) begin
        e = {bits[b], 1'b1, ((b == nb-1) && (c == t-1)), 1'b0};
        if (which == 1) q1.push_back(e); else q2.push_back(e);
      end
  endtask

  task automatic send(input int which, input logic [7:0] d);
    int budget = 0;
    @(negedge clk);
    data = d;
    if (which == 1) valid1 = 1'b1; else valid2 = 1'b1;
    while (!((which == 1) ? ready1 : ready2) && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 20000) begin
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    @(posedge clk);
    push_frame(which, d);
  endtask

  task automatic drain();
    int budget = 0;
    @(negedge clk);
    valid1 = 1'b0;
    valid2 = 1'b0;
    while ((q1.size() != 0 || q2.size() != 0) && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 20000) chk("drain_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic set_cfg(input logic [11:0] p, input logic [3:0] n,
                         input logic en, input logic odd, input logic be);
    @(negedge clk);
    acq_p = p; acq_n = n; pen = en; podd = odd; big = be;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      e1 = (q1.size() != 0) ? q1.pop_front() : 4'b1001;
      e2 = (q2.size() != 0) ? q2.pop_front() : 4'b1001;
      chk("dut1_tx_busy_done_rdy", {28'd0, tx1, busy1, done1, ready1}, {28'd0, e1});
      chk("dut2_tx_busy_done_rdy", {28'd0, tx2, busy2, done2, ready2}, {28'd0, e2});
    end
  end

  initial begin
    rst = 1'b0; mon_on = 1'b0; valid1 = 1'b0; valid2 = 1'b0; data = 8'h00;
    acq_p = 12'd4; acq_n = 4'd3; pen = 1'b1; podd = 1'b0; big = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx1}, 32'd1);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_done", {31'd0, done1}, 32'd0);
    chk("rst_ready", {31'd0, ready1}, 32'd1);
    rst = 1'b1;
    mon_on = 1'b1;

    // P=4 N=3 even parity LSB first
    send(1, 8'hA5);
    drain();
    // MSB first, odd parity
    set_cfg(12'd4, 4'd3, 1'b1, 1'b1, 1'b1);
    send(1, 8'h01);
    drain();
    // two stop bits, 1-clock bits, back-to-back with valid held
    set_cfg(12'd1, 4'd1, 1'b0, 1'b0, 1'b0);
    send(2, 8'hFF);
    send(2, 8'h00);
    drain();
    // zero config treated as 1; P changes mid-frame
    set_cfg(12'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    send(1, 8'h96);
    @(negedge clk);
    acq_p = 12'd20;
    send(1, 8'h6B);
    drain();
    // reset during data bit 3
    set_cfg(12'd4, 4'd1, 1'b0, 1'b0, 1'b0);
    send(1, 8'h3C);
    @(negedge clk);
    valid1 = 1'b0;
    repeat (17) @(posedge clk);
    #2 rst = 1'b0;
    q1.delete();
    #1;
    chk("abort_tx", {31'd0, tx1}, 32'd1);
    chk("abort_busy", {31'd0, busy1}, 32'd0);
    chk("abort_ready", {31'd0, ready1}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    send(1, 8'h5A);
    drain();
    // default config: T = 300, odd parity
    set_cfg(12'd20, 4'd15, 1'b1, 1'b1, 1'b0);
    send(1, 8'h00);
    drain();

    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
